udma_eth_frame_cfg_mc: RTL and testbench

- Next-generation configuration register file for the ethernet-frame uDMA peripheral.
- Serves NUM_CH uDMA channels (default 2: ch0 = RX, ch1 = TX) behind one cfg bus.
- Adds deferred start: an enable written while the core queue is full is held and fired later.
- Adds per-channel sticky end-of-transfer flags, an interrupt mask and a registered irq_o.
- Sits between the SoC peripheral interconnect and the uDMA channel logic of the eth-frame peripheral.

---
 rtl/udma_eth_frame_pkg.sv | 35 +++
 rtl/udma_eth_frame_cfg_mc_if.sv | 24 ++
 rtl/udma_eth_frame_cfg_ch.sv | 81 ++++++++
 rtl/udma_eth_frame_cfg_mc.sv | 158 +++++++++++++++
 tb/tb_udma_eth_frame_cfg_mc.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/udma_eth_frame_pkg.sv
// udma_eth_frame_pkg
//   Shared definitions for the eth-frame uDMA configuration register file:
//   per-channel register offsets, CFG register bit positions, the IRQ error
//   bit, and helpers that locate the IRQ_STATUS / IRQ_MASK words at the top
//   of the cfg address space.
package udma_eth_frame_pkg;

  // Word offset of a register inside a channel's 4-word window.
  typedef enum logic [1:0] {
    REG_SADDR = 2'd0,
    REG_SIZE  = 2'd1,
    REG_CFG   = 2'd2,
    REG_RSVD  = 2'd3
  } reg_off_e;

  // CFG register bit positions (write and readback share the layout).
  localparam int unsigned CFG_CONT_BIT  = 0;
  localparam int unsigned CFG_EN_BIT    = 4;
  localparam int unsigned CFG_PEND_BIT  = 5;
  localparam int unsigned CFG_CLR_BIT   = 6;
  localparam int unsigned CFG_DEFER_BIT = 7;

  // IRQ_STATUS / IRQ_MASK bit flagging an access to an unmapped address.
  localparam int unsigned IRQ_ERR_BIT = 31;

  // IRQ_STATUS sits one word below the top of the cfg space, IRQ_MASK at the top.
  function automatic int unsigned irq_status_addr(input int unsigned aw);
    return (32'd1 << aw) - 32'd2;
  endfunction

  function automatic int unsigned irq_mask_addr(input int unsigned aw);
    return (32'd1 << aw) - 32'd1;
  endfunction

endpackage

// File: rtl/udma_eth_frame_cfg_mc_if.sv
// udma_eth_frame_cfg_mc_if
//   Peripheral-interconnect cfg bus of the eth-frame uDMA register file.
//   master: interconnect side (drives data/addr/valid/rwn).
//   slave : register file side (drives combinational read data and ready).
interface udma_eth_frame_cfg_mc_if #(
  parameter int unsigned CFG_AW = 5
);
  logic [31:0]       cfg_data_i;
  logic [CFG_AW-1:0] cfg_addr_i;
  logic              cfg_valid_i;
  logic              cfg_rwn_i;
  logic [31:0]       cfg_data_o;
  logic              cfg_ready_o;

  modport master (
    output cfg_data_i, cfg_addr_i, cfg_valid_i, cfg_rwn_i,
    input  cfg_data_o, cfg_ready_o
  );

  modport slave (
    input  cfg_data_i, cfg_addr_i, cfg_valid_i, cfg_rwn_i,
    output cfg_data_o, cfg_ready_o
  );
endinterface

// File: rtl/udma_eth_frame_cfg_ch.sv
// udma_eth_frame_cfg_ch
//   One uDMA channel of the eth-frame cfg register file: start address, size
//   and continuous registers, one-cycle en/clr pulses, deferred start while
//   the core queue is full, and falling-edge detect of the core busy flag.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   wr_saddr/size/cfg     decoded write strobes for this channel
//   wdata                 cfg write data
//   en_i, pending_i       core busy / queue-full for this channel
//   startaddr, size, continuous, en_o, clr_o   register outputs
//   deferred              start request parked behind a full queue
//   done                  en_i fell this cycle (status set on next edge)
//   en_req, size_zero     inputs to the optional error flag
module udma_eth_frame_cfg_ch
  import udma_eth_frame_pkg::*;
#(
  parameter int unsigned L2_AWIDTH_NOAL = 12,
  parameter int unsigned TRANS_SIZE     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      wr_saddr,
  input  logic                      wr_size,
  input  logic                      wr_cfg,
  input  logic [31:0]               wdata,
  input  logic                      en_i,
  input  logic                      pending_i,
  output logic [L2_AWIDTH_NOAL-1:0] startaddr,
  output logic [TRANS_SIZE-1:0]     size,
  output logic                      continuous,
  output logic                      en_o,
  output logic                      clr_o,
  output logic                      deferred,
  output logic                      done,
  output logic                      en_req,
  output logic                      size_zero
);

  logic en_prev;
  logic wr_clr;
  logic unused_wdata;

  assign wr_clr       = wr_cfg & wdata[CFG_CLR_BIT];
  assign en_req       = wr_cfg & wdata[CFG_EN_BIT] & ~wdata[CFG_CLR_BIT];
  assign size_zero    = (size == '0);
  assign done         = en_prev & ~en_i;
  assign unused_wdata = ^wdata;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      startaddr  <= '0;
      size       <= '0;
      continuous <= 1'b0;
      en_o       <= 1'b0;
      clr_o      <= 1'b0;
      deferred   <= 1'b0;
      en_prev    <= 1'b0;
    end else begin
      en_o    <= 1'b0;
      clr_o   <= 1'b0;
      en_prev <= en_i;
      if (wr_saddr) startaddr <= wdata[L2_AWIDTH_NOAL-1:0];
      if (wr_size)  size      <= wdata[TRANS_SIZE-1:0];
      if (wr_cfg)   continuous <= wdata[CFG_CONT_BIT];
      // A fresh en write and a parked one are handled alike: fire when the
      // queue has room, otherwise (re)park. A second en while parked merges.
      if (wr_clr) begin
        clr_o    <= 1'b1;
        deferred <= 1'b0;
      end else if (en_req || deferred) begin
        if (pending_i) begin
          deferred <= 1'b1;
        end else begin
          en_o     <= 1'b1;
          deferred <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/udma_eth_frame_cfg_mc.sv
// udma_eth_frame_cfg_mc
//   Multi-channel cfg register file of the eth-frame uDMA peripheral. Decodes
//   the cfg bus, muxes combinational readback, instantiates one
//   udma_eth_frame_cfg_ch per channel and holds IRQ_STATUS / IRQ_MASK / irq_o.
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   cfg                  cfg bus (slave modport)
//   cfg_startaddr_o, cfg_size_o, cfg_continuous_o   per-channel registers
//   cfg_en_o, cfg_clr_o  one-cycle start / clear pulses
//   cfg_en_i, cfg_pending_i, cfg_curr_addr_i, cfg_bytes_left_i   core status
//   irq_o                registered |(status & mask)
// Build option:
//   UDMA_ETH_FRAME_CFG_ERR_EN  adds per-channel size-0 start error bits
//   (IRQ_STATUS[NUM_CH+ch]) and an unmapped-access error bit (bit 31).
module udma_eth_frame_cfg_mc
  import udma_eth_frame_pkg::*;
#(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned L2_AWIDTH_NOAL = 12,
  parameter int unsigned TRANS_SIZE     = 16,
  parameter int unsigned CFG_AW         = 5
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  udma_eth_frame_cfg_mc_if.slave                cfg,
  output logic [NUM_CH-1:0][L2_AWIDTH_NOAL-1:0] cfg_startaddr_o,
  output logic [NUM_CH-1:0][TRANS_SIZE-1:0]     cfg_size_o,
  output logic [NUM_CH-1:0]                     cfg_continuous_o,
  output logic [NUM_CH-1:0]                     cfg_en_o,
  output logic [NUM_CH-1:0]                     cfg_clr_o,
  input  logic [NUM_CH-1:0]                     cfg_en_i,
  input  logic [NUM_CH-1:0]                     cfg_pending_i,
  input  logic [NUM_CH-1:0][L2_AWIDTH_NOAL-1:0] cfg_curr_addr_i,
  input  logic [NUM_CH-1:0][TRANS_SIZE-1:0]     cfg_bytes_left_i,
  output logic                                  irq_o
);

  localparam logic [CFG_AW-1:0] STATUS_ADDR = CFG_AW'(irq_status_addr(CFG_AW));
  localparam logic [CFG_AW-1:0] MASK_ADDR   = CFG_AW'(irq_mask_addr(CFG_AW));
  localparam logic [31:0]       CH_BITS     = 32'((64'd1 << NUM_CH) - 64'd1);
`ifdef UDMA_ETH_FRAME_CFG_ERR_EN
  localparam logic [31:0] IMPL_BITS = CH_BITS | (CH_BITS << NUM_CH) | (32'd1 << IRQ_ERR_BIT);
`else
  localparam logic [31:0] IMPL_BITS = CH_BITS;
`endif

  int unsigned a_ch;
  reg_off_e    a_reg;
  logic        ch_hit, stat_hit, mask_hit, wr, unmapped;

  logic [NUM_CH-1:0] wr_saddr, wr_size, wr_cfg;
  logic [NUM_CH-1:0] deferred, done, en_req, size_zero;

  logic [31:0] status_q, mask_q, status_nxt, set_vec, clr_vec, rdata;

  always_comb begin
    a_ch     = 32'(cfg.cfg_addr_i[CFG_AW-1:2]);
    a_reg    = reg_off_e'(cfg.cfg_addr_i[1:0]);
    ch_hit   = (a_ch < NUM_CH) && (a_reg != REG_RSVD);
    stat_hit = (cfg.cfg_addr_i == STATUS_ADDR);
    mask_hit = (cfg.cfg_addr_i == MASK_ADDR);
    wr       = cfg.cfg_valid_i & ~cfg.cfg_rwn_i;
    unmapped = cfg.cfg_valid_i & ~ch_hit & ~stat_hit & ~mask_hit;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic sel;
    assign sel         = wr && ch_hit && (a_ch == unsigned'(c));
    assign wr_saddr[c] = sel && (a_reg == REG_SADDR);
    assign wr_size[c]  = sel && (a_reg == REG_SIZE);
    assign wr_cfg[c]   = sel && (a_reg == REG_CFG);

    udma_eth_frame_cfg_ch #(
      .L2_AWIDTH_NOAL (L2_AWIDTH_NOAL),
      .TRANS_SIZE     (TRANS_SIZE)
    ) u_ch (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wr_saddr   (wr_saddr[c]),
      .wr_size    (wr_size[c]),
      .wr_cfg     (wr_cfg[c]),
      .wdata      (cfg.cfg_data_i),
      .en_i       (cfg_en_i[c]),
      .pending_i  (cfg_pending_i[c]),
      .startaddr  (cfg_startaddr_o[c]),
      .size       (cfg_size_o[c]),
      .continuous (cfg_continuous_o[c]),
      .en_o       (cfg_en_o[c]),
      .clr_o      (cfg_clr_o[c]),
      .deferred   (deferred[c]),
      .done       (done[c]),
      .en_req     (en_req[c]),
      .size_zero  (size_zero[c])
    );
  end

`ifndef UDMA_ETH_FRAME_CFG_ERR_EN
  logic unused_err;
  assign unused_err = ^{en_req, size_zero, unmapped};
`endif

  // Sets are OR-ed in after the W1C so a same-cycle event is never lost.
  always_comb begin
    set_vec = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      set_vec[c] = done[c];
`ifdef UDMA_ETH_FRAME_CFG_ERR_EN
      set_vec[NUM_CH+c] = en_req[c] & size_zero[c];
`endif
    end
`ifdef UDMA_ETH_FRAME_CFG_ERR_EN
    set_vec[IRQ_ERR_BIT] = unmapped;
`endif
    clr_vec    = (wr && stat_hit) ? cfg.cfg_data_i : '0;
    status_nxt = ((status_q & ~clr_vec) | set_vec) & IMPL_BITS;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      status_q <= '0;
      mask_q   <= '0;
      irq_o    <= 1'b0;
    end else begin
      status_q <= status_nxt;
      if (wr && mask_hit) mask_q <= cfg.cfg_data_i & IMPL_BITS;
      irq_o <= |(status_q & mask_q);
    end
  end

  always_comb begin
    rdata = '0;
    if (stat_hit) begin
      rdata = status_q;
    end else if (mask_hit) begin
      rdata = mask_q;
    end else if (ch_hit) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (a_ch == c) begin
          case (a_reg)
            REG_SADDR: rdata = 32'(cfg_curr_addr_i[c]);
            REG_SIZE:  rdata = 32'(cfg_bytes_left_i[c]);
            REG_CFG: begin
              rdata[CFG_CONT_BIT]  = cfg_continuous_o[c];
              rdata[CFG_EN_BIT]    = cfg_en_i[c];
              rdata[CFG_PEND_BIT]  = cfg_pending_i[c];
              rdata[CFG_DEFER_BIT] = deferred[c];
            end
            default: rdata = '0;
          endcase
        end
      end
    end
  end

  assign cfg.cfg_data_o  = rdata;
  assign cfg.cfg_ready_o = 1'b1;

endmodule

// File: tb/tb_udma_eth_frame_cfg_mc.sv
// Testbench for udma_eth_frame_cfg_mc: randomized cfg traffic and core status
// against a behavioural register-file model, plus directed scenarios with
// hand-computed expectations.
module tb_udma_eth_frame_cfg_mc;
  localparam int unsigned NUM_CH = 2;
  localparam int unsigned AW     = 12;
  localparam int unsigned TS     = 16;
  localparam int unsigned CFG_AW = 5;
`ifdef UDMA_ETH_FRAME_CFG_ERR_EN
  localparam logic [31:0] IMPL = 32'h8000_000F;
`else
  localparam logic [31:0] IMPL = 32'h0000_0003;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  udma_eth_frame_cfg_mc_if #(.CFG_AW(CFG_AW)) cfg ();

  logic [NUM_CH-1:0][AW-1:0] startaddr, curr_addr;
  logic [NUM_CH-1:0][TS-1:0] size_o, bytes_left;
  logic [NUM_CH-1:0]         cont_o, en_o, clr_o, en_in, pend;
  logic                      irq;

  udma_eth_frame_cfg_mc #(
    .NUM_CH         (NUM_CH),
    .L2_AWIDTH_NOAL (AW),
    .TRANS_SIZE     (TS),
    .CFG_AW         (CFG_AW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .cfg              (cfg),
    .cfg_startaddr_o  (startaddr),
    .cfg_size_o       (size_o),
    .cfg_continuous_o (cont_o),
    .cfg_en_o         (en_o),
    .cfg_clr_o        (clr_o),
    .cfg_en_i         (en_in),
    .cfg_pending_i    (pend),
    .cfg_curr_addr_i  (curr_addr),
    .cfg_bytes_left_i (bytes_left),
    .irq_o            (irq)
  );

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [AW-1:0]     m_saddr [NUM_CH];
  logic [TS-1:0]     m_size  [NUM_CH];
  logic              m_cont  [NUM_CH];
  logic              m_def   [NUM_CH];
  logic              m_prev  [NUM_CH];
  logic [NUM_CH-1:0] m_en_p, m_clr_p;
  logic [31:0]       m_status, m_mask;
  logic              m_irq;

  always @(posedge clk or posedge rst) begin : model
    logic [31:0] setv, d;
    logic        w, cw, mapped, nirq;
    int unsigned a, ch, r;
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_saddr[c] = '0; m_size[c] = '0; m_cont[c] = 1'b0;
        m_def[c] = 1'b0; m_prev[c] = 1'b0;
      end
      m_en_p = '0; m_clr_p = '0; m_status = '0; m_mask = '0; m_irq = 1'b0;
    end else begin
      nirq   = |(m_status & m_mask);
      setv   = '0;
      d      = cfg.cfg_data_i;
      a      = 32'(cfg.cfg_addr_i);
      ch     = a / 4;
      r      = a % 4;
      w      = cfg.cfg_valid_i && !cfg.cfg_rwn_i;
      mapped = (ch < NUM_CH && r != 3) || a == 30 || a == 31;
      m_en_p = '0;
      m_clr_p = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        cw = w && ch == c && r == 2;
        if (m_prev[c] && !en_in[c]) setv[c] = 1'b1;
        m_prev[c] = en_in[c];
        if (cw && d[4] && !d[6] && m_size[c] == '0) setv[NUM_CH+c] = 1'b1;
        if (w && ch == c && r == 0) m_saddr[c] = d[AW-1:0];
        if (w && ch == c && r == 1) m_size[c] = d[TS-1:0];
        if (cw) m_cont[c] = d[0];
        if (cw && d[6]) begin
          m_clr_p[c] = 1'b1;
          m_def[c] = 1'b0;
        end else if ((cw && d[4]) || m_def[c]) begin
          if (pend[c]) m_def[c] = 1'b1;
          else begin
            m_en_p[c] = 1'b1;
            m_def[c] = 1'b0;
          end
        end
      end
      if (cfg.cfg_valid_i && !mapped) setv[31] = 1'b1;
      if (w && a == 30) m_status = m_status & ~d;
      m_status = (m_status | setv) & IMPL;
      if (w && a == 31) m_mask = d & IMPL;
      m_irq = nirq;
    end
  end

  function automatic logic [31:0] exp_rd(input int unsigned a);
    int unsigned ch, r;
    ch = a / 4;
    r  = a % 4;
    if (a == 30) return m_status;
    if (a == 31) return m_mask;
    if (ch >= NUM_CH) return 32'h0;
    case (r)
      0: return 32'(curr_addr[ch]);
      1: return 32'(bytes_left[ch]);
      2: return (32'(m_def[ch]) << 7) | (32'(pend[ch]) << 5) |
                (32'(en_in[ch]) << 4) | 32'(m_cont[ch]);
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      chk("startaddr", 32'(startaddr[c]), 32'(m_saddr[c]));
      chk("size", 32'(size_o[c]), 32'(m_size[c]));
      chk("continuous", 32'(cont_o[c]), 32'(m_cont[c]));
    end
    chk("en_pulse", 32'(en_o), 32'(m_en_p));
    chk("clr_pulse", 32'(clr_o), 32'(m_clr_p));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("ready", 32'(cfg.cfg_ready_o), 32'h1);
    if (cfg.cfg_valid_i && cfg.cfg_rwn_i)
      chk("rdata", cfg.cfg_data_o, exp_rd(32'(cfg.cfg_addr_i)));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cfg.cfg_valid_i = 1'b1; cfg.cfg_rwn_i = 1'b0;
    cfg.cfg_addr_i = a; cfg.cfg_data_i = d;
    step();
    cfg.cfg_valid_i = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    cfg.cfg_valid_i = 1'b1; cfg.cfg_rwn_i = 1'b1; cfg.cfg_addr_i = a;
    #1;
    chk(name, cfg.cfg_data_o, exp);
    step();
    cfg.cfg_valid_i = 1'b0;
  endtask

  task automatic rand_traffic(input int unsigned n);
    logic [31:0] d;
    for (int unsigned i = 0; i < n; i++) begin
      cfg.cfg_valid_i = ($urandom_range(0, 3) != 0);
      cfg.cfg_rwn_i   = $urandom_range(0, 1) != 0;
      case ($urandom_range(0, 3))
        0, 1:    cfg.cfg_addr_i = 5'($urandom_range(0, 7));
        2:       cfg.cfg_addr_i = 5'($urandom_range(30, 31));
        default: cfg.cfg_addr_i = 5'($urandom_range(0, 31));
      endcase
      d = $urandom;
      if ($urandom_range(0, 3) == 0) d[15:0] = '0;
      if ($urandom_range(0, 1) == 0) d[6] = 1'b0;
      cfg.cfg_data_i = d;
      if ($urandom_range(0, 3) == 0) pend  = pend ^ 2'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) en_in = en_in ^ 2'($urandom_range(1, 3));
      curr_addr  = {AW'($urandom), AW'($urandom)};
      bytes_left = {TS'($urandom), TS'($urandom)};
      step();
    end
  endtask

  initial begin
    cfg.cfg_valid_i = 1'b0; cfg.cfg_rwn_i = 1'b1;
    cfg.cfg_addr_i = '0; cfg.cfg_data_i = '0;
    en_in = '0; pend = '0; curr_addr = '0; bytes_left = '0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    rand_traffic(400);

    // reset in the middle of traffic
    rst = 1'b1;
    #1;
    chk("rst_startaddr", 32'(startaddr), 32'h0);
    chk("rst_size", 32'(size_o), 32'h0);
    chk("rst_cont_en_clr", 32'({cont_o, en_o, clr_o}), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_ready", 32'(cfg.cfg_ready_o), 32'h1);
    cfg.cfg_valid_i = 1'b1; cfg.cfg_rwn_i = 1'b1; cfg.cfg_addr_i = 5'd6;
    pend = '0; en_in = '0;
    #1;
    chk("rst_cfg1_read", cfg.cfg_data_o, 32'h0);
    step(); step();
    cfg.cfg_valid_i = 1'b0;
    rst = 1'b0;
    step();

    // ch0 program and start
    wr(5'd0, 32'h123);
    wr(5'd1, 32'h40);
    wr(5'd2, 32'h11);
    chk("ch0_en_pulse", 32'(en_o), 32'h1);
    chk("ch0_cont", 32'(cont_o[0]), 32'h1);
    chk("ch0_saddr", 32'(startaddr[0]), 32'h123);
    chk("ch0_size", 32'(size_o[0]), 32'h40);
    step();
    chk("ch0_en_single", 32'(en_o), 32'h0);

    // deferred start on ch1
    wr(5'd5, 32'h20);
    pend = 2'b10;
    wr(5'd6, 32'h10);
    chk("defer_no_pulse", 32'(en_o), 32'h0);
    rd_chk("defer_flag", 5'd6, 32'hA0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("defer_hold", 32'(en_o), 32'h0);
    end
    pend = 2'b00;
    step();
    chk("defer_fire", 32'(en_o), 32'h2);
    rd_chk("defer_cleared", 5'd6, 32'h00);
    chk("defer_single", 32'(en_o), 32'h0);

    // clr wins over a parked start
    pend = 2'b10;
    wr(5'd6, 32'h10);
    rd_chk("clr_pre_defer", 5'd6, 32'hA0);
    wr(5'd6, 32'h50);
    chk("clr_pulse", 32'(clr_o), 32'h2);
    chk("clr_no_en", 32'(en_o), 32'h0);
    rd_chk("clr_defer_gone", 5'd6, 32'h20);
    pend = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("clr_no_late_en", 32'(en_o), 32'h0);
    end

    // done detection and irq
    wr(5'd30, 32'hFFFF_FFFF);
    wr(5'd31, 32'h3);
    en_in = 2'b11;
    step(); step();
    en_in = 2'b10;
    step();
    chk("irq_lag", 32'(irq), 32'h0);
    rd_chk("status_ch0", 5'd30, 32'h1);
    chk("irq_set", 32'(irq), 32'h1);
    en_in = 2'b00;
    wr(5'd30, 32'h1);
    chk("irq_hold_a", 32'(irq), 32'h1);
    rd_chk("status_set_wins", 5'd30, 32'h2);
    chk("irq_hold_b", 32'(irq), 32'h1);
    wr(5'd30, 32'h2);
    step();
    chk("irq_clear", 32'(irq), 32'h0);

`ifdef UDMA_ETH_FRAME_CFG_ERR_EN
    wr(5'd30, 32'hFFFF_FFFF);
    wr(5'd1, 32'h0);
    wr(5'd2, 32'h10);
    rd_chk("err_size0", 5'd30, 32'h4);
    rd_chk("unmapped_read", 5'd3, 32'h0);
    rd_chk("err_unmapped", 5'd30, 32'h8000_0004);
`endif

    rand_traffic(1500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
